// File: rtl/r4u1_twiddle_mult_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | r4u1_twiddle_mult_if : sample stream, twiddle ROM and result bus     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface r4u1_twiddle_mult_if #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16
);
    logic                           din_valid;
    logic                           din_sop;
    logic signed [DATA_WIDTH-1:0]   din_re;
    logic signed [DATA_WIDTH-1:0]   din_im;
    logic        [2:0]              rom_addr;
    logic        [2*COEF_WIDTH-1:0] rom_data;
    logic                           dout_valid;
    logic                           dout_sop;
    logic signed [DATA_WIDTH-1:0]   dout_re;
    logic signed [DATA_WIDTH-1:0]   dout_im;

    modport master (
        output din_valid, din_sop, din_re, din_im, rom_data,
        input  rom_addr, dout_valid, dout_sop, dout_re, dout_im
    );

    modport slave (
        input  din_valid, din_sop, din_re, din_im, rom_data,
        output rom_addr, dout_valid, dout_sop, dout_re, dout_im
    );
endinterface
`default_nettype wire

// File: rtl/r4u1_twiddle_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | r4u1_twiddle_mult : radix-4 unit 1 twiddle multiply, 3-cycle pipe    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifndef COEF_WIDTH
`define COEF_WIDTH 16
`endif

module r4u1_twiddle_mult #(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = `COEF_WIDTH,
    parameter int FRAME_LEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    r4u1_twiddle_mult_if.slave   tw_if
);

    localparam int CNT_W  = $clog2(FRAME_LEN);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam int SUM_W  = PROD_W + 1;
    localparam int SHIFT  = COEF_WIDTH - 2;

    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-DATA_WIDTH){1'b0}}, OUT_MAX};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-DATA_WIDTH){1'b1}}, OUT_MIN};
    localparam logic signed [SUM_W-1:0] RND     = {{(SUM_W-1){1'b0}}, 1'b1} << (COEF_WIDTH-3);

    function automatic logic signed [DATA_WIDTH-1:0] sat_round(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0]      r;
        logic signed [DATA_WIDTH-1:0] res;
        r = (v + RND) >>> SHIFT;
        if (r > SAT_MAX)
            res = OUT_MAX;
        else if (r < SAT_MIN)
            res = OUT_MIN;
        else
            res = r[DATA_WIDTH-1:0];
        return res;
    endfunction

    // Frame position counter
    logic [CNT_W-1:0] cnt_q, cnt_d, idx;

    always_comb begin
        idx   = tw_if.din_sop ? '0 : cnt_q;
        cnt_d = cnt_q;
        if (tw_if.din_valid)
            cnt_d = idx + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // S1: capture sample and its group / twiddle index; twiddle index drives the ROM
    logic                         s1_valid_q, s1_sop_q;
    logic signed [DATA_WIDTH-1:0] s1_re_q, s1_im_q;
    logic        [1:0]            s1_grp_q;
    logic        [2:0]            s1_twi_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sop_q   <= 1'b0;
            s1_re_q    <= '0;
            s1_im_q    <= '0;
            s1_grp_q   <= '0;
            s1_twi_q   <= '0;
        end else begin
            s1_valid_q <= tw_if.din_valid;
            s1_sop_q   <= tw_if.din_valid & tw_if.din_sop;
            if (tw_if.din_valid) begin
                s1_re_q  <= tw_if.din_re;
                s1_im_q  <= tw_if.din_im;
                s1_grp_q <= idx[CNT_W-1:CNT_W-2];
                s1_twi_q <= idx[2:0];
            end
        end
    end

    assign tw_if.rom_addr = s1_twi_q;

    logic signed [COEF_WIDTH-1:0] b_re, b_im;
    assign b_re = tw_if.rom_data[2*COEF_WIDTH-1:COEF_WIDTH];
    assign b_im = tw_if.rom_data[COEF_WIDTH-1:0];

    // S2: partial products plus the raw sample for the group-0 bypass
    logic                         s2_valid_q, s2_sop_q, s2_byp_q;
    logic signed [DATA_WIDTH-1:0] s2_re_q, s2_im_q;
    logic signed [PROD_W-1:0]     p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_sop_q   <= 1'b0;
            s2_byp_q   <= 1'b0;
            s2_re_q    <= '0;
            s2_im_q    <= '0;
            p_rr_q     <= '0;
            p_ii_q     <= '0;
            p_ri_q     <= '0;
            p_ir_q     <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_sop_q   <= s1_sop_q;
            if (s1_valid_q) begin
                s2_byp_q <= (s1_grp_q == 2'd0);
                s2_re_q  <= s1_re_q;
                s2_im_q  <= s1_im_q;
                p_rr_q   <= s1_re_q * b_re;
                p_ii_q   <= s1_im_q * b_im;
                p_ri_q   <= s1_re_q * b_im;
                p_ir_q   <= s1_im_q * b_re;
            end
        end
    end

    // S3: combine, round half-up, saturate
    logic signed [SUM_W-1:0]      re_full, im_full;
    logic signed [DATA_WIDTH-1:0] res_re, res_im;

    always_comb begin
        re_full = $signed({p_rr_q[PROD_W-1], p_rr_q}) - $signed({p_ii_q[PROD_W-1], p_ii_q});
        im_full = $signed({p_ri_q[PROD_W-1], p_ri_q}) + $signed({p_ir_q[PROD_W-1], p_ir_q});
        res_re  = s2_byp_q ? s2_re_q : sat_round(re_full);
        res_im  = s2_byp_q ? s2_im_q : sat_round(im_full);
    end

    logic                         dout_valid_q, dout_sop_q;
    logic signed [DATA_WIDTH-1:0] dout_re_q, dout_im_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_re_q    <= '0;
            dout_im_q    <= '0;
        end else begin
            dout_valid_q <= s2_valid_q;
            dout_sop_q   <= s2_sop_q;
            if (s2_valid_q) begin
                dout_re_q <= res_re;
                dout_im_q <= res_im;
            end
        end
    end

    assign tw_if.dout_valid = dout_valid_q;
    assign tw_if.dout_sop   = dout_sop_q;
    assign tw_if.dout_re    = dout_re_q;
    assign tw_if.dout_im    = dout_im_q;

endmodule
`default_nettype wire
